pool2x2_relu: RTL

Downstream stage of the 2-D convolution core: consumes the core's float32 output stream (`pxl_ena_z`/`pxl_z`), applies ReLU, and performs 2x2 stride-2 max pooling in raster order. It buffers one row of horizontal pair-maxima in on-chip RAM and emits one pooled float32 pixel per 2x2 window, plus a frame-done pulse, to the next layer's feeder.

---
 rtl/pool2x2_relu_pkg.sv | 38 +++
 rtl/pool_line_ram.sv | 30 +++
 rtl/pool2x2_relu.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pool2x2_relu_pkg.sv
// Shared types, constants and float helpers for the pooling stages.
package pool2x2_relu_pkg;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // IDLE waits for parameters, EVEN/ODD track the row parity,
  // DRAIN swallows the unpaired last row of an odd-height frame.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVEN  = 2'd1,
    ST_ODD   = 2'd2,
    ST_DRAIN = 2'd3
  } pool_state_t;

  // Clamp any value with the sign bit set (including -0.0) to +0.0.
  function automatic logic [31:0] fp_relu_f(input logic [31:0] x);
    return x[31] ? FP_ZERO : x;
  endfunction

  // Float maximum. With relu set both operands are known non-negative,
  // so the bit patterns order like unsigned integers. Otherwise the sign
  // decides first and two negatives order reversed on magnitude.
  function automatic logic [31:0] fp_max_f(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        relu);
    logic a_wins;
    if (relu)
      a_wins = (a[30:0] >= b[30:0]);
    else if (a[31] != b[31])
      a_wins = b[31];
    else if (a[31])
      a_wins = (a[30:0] <= b[30:0]);
    else
      a_wins = (a[30:0] >= b[30:0]);
    return a_wins ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_ram.sv
// Simple dual-port line buffer: one write port, one registered read port.
module pool_line_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // NOTE: the array and its read register carry no reset so the tools can
  // map them onto block RAM; contents are always written before being read.
  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; the word is held until the next read, which
  // bridges any gap between the read and the pixel that consumes it.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pool2x2_relu.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster float32 stream.
module pool2x2_relu
  import pool2x2_relu_pkg::*;
#(
  parameter int unsigned C_WIDTH = 9,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               param_ena,
  input  logic [C_WIDTH-1:0] param_width_in,
  input  logic [C_WIDTH-1:0] param_height_in,
  input  logic               pxl_ena_z,
  input  logic [31:0]        pxl_z,
  output logic               pxl_ena_p,
  output logic [31:0]        pxl_p,
  output logic               pool_done
);

  localparam logic [C_WIDTH-1:0] ONE = C_WIDTH'(1);
  localparam logic [C_WIDTH-1:0] TWO = C_WIDTH'(2);

  pool_state_t        state_q, state_d;
  logic [C_WIDTH-1:0] w_q, h_q;
  logic [C_WIDTH-1:0] col, row;
  logic [31:0]        pa;
  logic               done_q;

  logic               accept, col_last, row_last;
  logic               wr_en, rd_en, out_fire;
  logic [31:0]        pix, pair_max, win_max, rd_data;

  // Buffer addresses are the horizontal pair index.
  pool_line_ram #(
    .ADDR_W (C_WIDTH-1),
    .DATA_W (32)
  ) u_line_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (col[C_WIDTH-1:1]),
    .wr_data (pair_max),
    .rd_en   (rd_en),
    .rd_addr (col[C_WIDTH-1:1]),
    .rd_data (rd_data)
  );

  // Pixel qualification, datapath maxima and next-state selection.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch can be inferred.
    state_d  = state_q;
    accept   = pxl_ena_z && !param_ena && (state_q != ST_IDLE);
    col_last = (col == w_q - ONE);
    row_last = (row == h_q - ONE);
    pix      = RELU_EN ? fp_relu_f(pxl_z) : pxl_z;
    pair_max = fp_max_f(pa, pix, RELU_EN);
    win_max  = fp_max_f(rd_data, pair_max, RELU_EN);
    wr_en    = accept && (state_q == ST_EVEN) && col[0];
    rd_en    = accept && (state_q == ST_ODD) && !col[0];
    out_fire = accept && (state_q == ST_ODD) && col[0];

    if (param_ena) begin
      state_d = (param_width_in >= TWO && param_height_in >= TWO) ? ST_EVEN : ST_IDLE;
    end else if (accept && col_last) begin
      if (row_last)
        state_d = ST_IDLE;
      else if (h_q[0] && (row == h_q - TWO))
        state_d = ST_DRAIN;
      else
        state_d = (state_q == ST_EVEN) ? ST_ODD : ST_EVEN;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Dimension latch, raster counters, pair register and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q       <= '0;
      h_q       <= '0;
      col       <= '0;
      row       <= '0;
      pa        <= FP_ZERO;
      done_q    <= 1'b0;
      pxl_ena_p <= 1'b0;
      pxl_p     <= FP_ZERO;
      pool_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here update
      // from pre-edge values, independent of statement order.
      pxl_ena_p <= 1'b0;
      done_q    <= 1'b0;
      pool_done <= done_q;
      if (param_ena) begin
        w_q <= param_width_in;
        h_q <= param_height_in;
        col <= '0;
        row <= '0;
      end else if (accept) begin
        if (!col[0]) pa <= pix;
        if (out_fire) begin
          pxl_ena_p <= 1'b1;
          pxl_p     <= win_max;
        end
        if (col_last) begin
          col <= '0;
          if (row_last) begin
            row    <= '0;
            done_q <= 1'b1;
          end else begin
            row <= row + ONE;
          end
        end else begin
          col <= col + ONE;
        end
      end
    end
  end

endmodule
